intr_ctrl: RTL and testbench

Parametrised multi-source interrupt controller placed between external interrupt lines and the single-cycle CPU's `intr`/`inta` pins. It generalises the single-line interrupt to `NUM_SRC` sources. Each source is synchronised, optionally edge-detected, latched as pending, masked, and priority-encoded. A request/acknowledge/end-of-interrupt handshake delivers one vector at a time to the CPU.

---
 rtl/intr_pkg.sv | 26 ++
 rtl/intr_ctrl_if.sv | 29 ++
 rtl/intr_sync.sv | 28 ++
 rtl/intr_ctrl.sv | 114 +++++++++++
 tb/tb_intr_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/intr_pkg.sv
// Shared types and helpers for the multi-source interrupt controller:
// FSM state encoding, vector-width derivation and the priority encoder.
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Vector width for n sources; a single-bit vector is the floor.
    function automatic int calc_vw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Lowest set index wins; scanning downwards lets the last hit be the lowest.
    function automatic logic [4:0] prio_enc(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Bundle of interrupt lines, mask programming and the CPU handshake.
// slave = controller side, master = CPU / source side.
interface intr_ctrl_if
    import intr_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int VW      = calc_vw(NUM_SRC)
);
    logic [NUM_SRC-1:0] irq;
    logic               mask_we;
    logic [NUM_SRC-1:0] mask_wdata;
    logic               inta;
    logic               eoi;
    logic               intr;
    logic [VW-1:0]      vector;
    logic               in_service;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;

    modport slave (
        input  irq, mask_we, mask_wdata, inta, eoi,
        output intr, vector, in_service, pending, mask
    );

    modport master (
        output irq, mask_we, mask_wdata, inta, eoi,
        input  intr, vector, in_service, pending, mask
    );
endinterface

// File: rtl/intr_sync.sv
// Multi-bit flop-chain synchroniser for the raw asynchronous interrupt lines.
// Each bit is independent; no cross-bit coherency is implied.
module intr_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // NOTE: a flop array with async reset must clear every element in the reset
    // branch; leaving any out turns it into a mix of reset and non-reset flops.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/intr_ctrl.sv
// NUM_SRC-source interrupt controller: synchronise, detect, latch, mask,
// priority-encode and hand one vector at a time to the CPU via intr/inta/eoi.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter bit EDGE        = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       resetn,
    intr_ctrl_if.slave bus
);

    localparam int VW = calc_vw(NUM_SRC);

    logic [NUM_SRC-1:0] s_irq;
    logic [NUM_SRC-1:0] s_irq_d;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] act;
    logic [NUM_SRC-1:0] clr;
    logic [VW-1:0]      winner;
    logic [VW-1:0]      vector_q;
    logic               intr_q;
    logic               in_service_q;
    logic               accept;
    state_t             state;

    intr_sync #(
        .WIDTH  (NUM_SRC),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (bus.irq),
        .q      (s_irq)
    );

    // Arbitration uses the mask as it stands before any write in this cycle.
    assign act    = pending_q & ~mask_q;
    assign winner = VW'(prio_enc(32'(act)));
    assign accept = (state == REQ) && bus.inta && (act != '0);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        clr = '0;
        if (accept) clr[winner] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s_irq_d   <= '0;
            pending_q <= '0;
            mask_q    <= '1;
        end else begin
            s_irq_d <= s_irq;
            if (bus.mask_we) mask_q <= bus.mask_wdata;
            // Edge mode: a rising edge in the same cycle as the ack clear wins.
            if (EDGE) pending_q <= (pending_q & ~clr) | (s_irq & ~s_irq_d);
            else      pending_q <= s_irq;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            intr_q       <= 1'b0;
            in_service_q <= 1'b0;
            vector_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (act != '0) begin
                        state  <= REQ;
                        intr_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (accept) begin
                        state        <= SERVICE;
                        vector_q     <= winner;
                        in_service_q <= 1'b1;
                        intr_q       <= 1'b0;
                    end else if (act == '0) begin
                        // Request withdrawn by a mask write or a level drop.
                        state  <= IDLE;
                        intr_q <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (bus.eoi) begin
                        state        <= IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    intr_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.intr       = intr_q;
    assign bus.vector     = vector_q;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;
    assign bus.mask       = mask_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: an edge-mode instance checked through a vector
// scoreboard plus direct checks, and a level-mode instance checked directly.
module tb_intr_ctrl;

    logic clock;
    logic resetn;

    intr_ctrl_if #(.NUM_SRC(8)) e_if ();
    intr_ctrl_if #(.NUM_SRC(8)) l_if ();

    intr_ctrl #(.NUM_SRC(8), .EDGE(1'b1), .SYNC_STAGES(2)) u_edge (
        .clock  (clock),
        .resetn (resetn),
        .bus    (e_if.slave)
    );

    intr_ctrl #(.NUM_SRC(8), .EDGE(1'b0), .SYNC_STAGES(2)) u_level (
        .clock  (clock),
        .resetn (resetn),
        .bus    (l_if.slave)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_vec_q [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic write_mask(input bit lv, input logic [7:0] v);
        if (lv) begin l_if.mask_we = 1'b1; l_if.mask_wdata = v; end
        else    begin e_if.mask_we = 1'b1; e_if.mask_wdata = v; end
        tick(1);
        l_if.mask_we = 1'b0;
        e_if.mask_we = 1'b0;
    endtask

    task automatic pulse_irq(input int i);
        e_if.irq[i] = 1'b1;
        tick(1);
        e_if.irq[i] = 1'b0;
    endtask

    task automatic ack(input bit lv);
        if (lv) l_if.inta = 1'b1; else e_if.inta = 1'b1;
        tick(1);
        l_if.inta = 1'b0;
        e_if.inta = 1'b0;
    endtask

    task automatic end_irq(input bit lv);
        if (lv) l_if.eoi = 1'b1; else e_if.eoi = 1'b1;
        tick(1);
        l_if.eoi = 1'b0;
        e_if.eoi = 1'b0;
    endtask

    task automatic wait_intr(input bit lv, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen = lv ? l_if.intr : e_if.intr;
            if (seen) break;
            tick(1);
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Scoreboard monitor: each new in_service rise presents a vector to compare.
    initial begin
        logic prev;
        logic [31:0] exp;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (e_if.in_service && !prev) begin
                if (exp_vec_q.size() == 0) begin
                    check("unexpected_ack", 32'(e_if.vector), 32'hDEAD);
                end else begin
                    exp = exp_vec_q.pop_front();
                    check("sb_vector", 32'(e_if.vector), exp);
                end
            end
            prev = e_if.in_service;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        e_if.irq = '0; e_if.mask_we = 1'b0; e_if.mask_wdata = '0; e_if.inta = 1'b0; e_if.eoi = 1'b0;
        l_if.irq = '0; l_if.mask_we = 1'b0; l_if.mask_wdata = '0; l_if.inta = 1'b0; l_if.eoi = 1'b0;
        resetn = 1'b0;
        tick(3);
        resetn = 1'b1;
        tick(1);

        check("rst_intr",       32'(e_if.intr),       32'd0);
        check("rst_in_service", 32'(e_if.in_service), 32'd0);
        check("rst_mask",       32'(e_if.mask),       32'hFF);
        check("rst_pending",    32'(e_if.pending),    32'd0);
        check("rst_vector",     32'(e_if.vector),     32'd0);

        // Single edge: intr exactly three edges after capture.
        write_mask(1'b0, 8'h00);
        e_if.irq[5] = 1'b1;
        tick(1);
        e_if.irq[5] = 1'b0;
        tick(2);
        check("single_intr_early", 32'(e_if.intr), 32'd0);
        check("single_pending",    32'(e_if.pending), 32'h20);
        tick(1);
        check("single_intr_t3", 32'(e_if.intr), 32'd1);
        exp_vec_q.push_back(32'd5);
        ack(1'b0);
        check("single_ack_pending", 32'(e_if.pending), 32'h00);
        check("single_ack_intr",    32'(e_if.intr), 32'd0);
        check("single_ack_insvc",   32'(e_if.in_service), 32'd1);
        end_irq(1'b0);
        check("single_eoi_insvc", 32'(e_if.in_service), 32'd0);

        // Priority plus a new source arriving during service.
        e_if.irq[6] = 1'b1; e_if.irq[2] = 1'b1;
        tick(1);
        e_if.irq[6] = 1'b0; e_if.irq[2] = 1'b0;
        wait_intr(1'b0, "prio_intr");
        exp_vec_q.push_back(32'd2);
        ack(1'b0);
        pulse_irq(0);
        tick(4);
        check("svc_pending",  32'(e_if.pending), 32'h41);
        check("svc_no_intr",  32'(e_if.intr), 32'd0);
        end_irq(1'b0);
        check("eoi_idle_intr", 32'(e_if.intr), 32'd0);
        tick(1);
        check("eoi_next_intr", 32'(e_if.intr), 32'd1);
        exp_vec_q.push_back(32'd0);
        ack(1'b0);
        end_irq(1'b0);
        wait_intr(1'b0, "prio_intr6");
        exp_vec_q.push_back(32'd6);
        ack(1'b0);
        end_irq(1'b0);
        check("prio_drained", 32'(e_if.pending), 32'h00);

        // Masking and request withdrawal.
        write_mask(1'b0, 8'h04);
        pulse_irq(2);
        tick(4);
        check("mask_pending", 32'(e_if.pending), 32'h04);
        check("mask_no_intr", 32'(e_if.intr), 32'd0);
        write_mask(1'b0, 8'h00);
        check("unmask_same_edge", 32'(e_if.intr), 32'd0);
        tick(1);
        check("unmask_intr", 32'(e_if.intr), 32'd1);
        write_mask(1'b0, 8'h04);
        check("remask_still_req", 32'(e_if.intr), 32'd1);
        tick(1);
        check("remask_withdrawn", 32'(e_if.intr), 32'd0);
        tick(2);
        check("remask_stay_idle", 32'(e_if.intr), 32'd0);
        write_mask(1'b0, 8'h00);
        tick(1);
        check("unmask_again", 32'(e_if.intr), 32'd1);
        exp_vec_q.push_back(32'd2);
        ack(1'b0);
        end_irq(1'b0);

        // Ignored pulses: inta in IDLE, eoi in REQ.
        ack(1'b0);
        check("idle_inta_insvc",  32'(e_if.in_service), 32'd0);
        check("idle_inta_intr",   32'(e_if.intr), 32'd0);
        check("idle_inta_vector", 32'(e_if.vector), 32'd2);
        pulse_irq(1);
        wait_intr(1'b0, "ign_intr");
        end_irq(1'b0);
        check("req_eoi_intr",  32'(e_if.intr), 32'd1);
        check("req_eoi_insvc", 32'(e_if.in_service), 32'd0);
        exp_vec_q.push_back(32'd1);
        ack(1'b0);
        end_irq(1'b0);

        // New irq[5] edge lands on the same edge as the ack of source 5.
        e_if.irq[5] = 1'b1; tick(1);
        e_if.irq[5] = 1'b0; tick(1);
        e_if.irq[5] = 1'b1; tick(1);
        e_if.irq[5] = 1'b0; tick(1);
        check("simul_intr", 32'(e_if.intr), 32'd1);
        exp_vec_q.push_back(32'd5);
        ack(1'b0);
        check("simul_set_wins", 32'(e_if.pending), 32'h20);
        check("simul_insvc",    32'(e_if.in_service), 32'd1);
        end_irq(1'b0);
        wait_intr(1'b0, "simul_rereq");
        exp_vec_q.push_back(32'd5);
        ack(1'b0);
        check("simul_cleared", 32'(e_if.pending), 32'h00);
        end_irq(1'b0);

        // Level mode: held line re-requests after eoi, dropped line does not.
        write_mask(1'b1, 8'h00);
        l_if.irq[3] = 1'b1;
        wait_intr(1'b1, "lvl_intr");
        ack(1'b1);
        check("lvl_vector",  32'(l_if.vector), 32'd3);
        check("lvl_pending", 32'(l_if.pending), 32'h08);
        check("lvl_insvc",   32'(l_if.in_service), 32'd1);
        end_irq(1'b1);
        check("lvl_eoi_insvc", 32'(l_if.in_service), 32'd0);
        tick(1);
        check("lvl_rereq", 32'(l_if.intr), 32'd1);
        ack(1'b1);
        l_if.irq[3] = 1'b0;
        tick(4);
        check("lvl_dropped", 32'(l_if.pending), 32'h00);
        end_irq(1'b1);
        tick(3);
        check("lvl_no_rereq", 32'(l_if.intr), 32'd0);

        // Reset asserted mid-SERVICE with an event in flight.
        pulse_irq(3);
        wait_intr(1'b0, "rst_pre_intr");
        exp_vec_q.push_back(32'd3);
        ack(1'b0);
        e_if.irq[4] = 1'b1;
        tick(1);
        resetn = 1'b0;
        #1;
        check("midrst_intr",    32'(e_if.intr),       32'd0);
        check("midrst_insvc",   32'(e_if.in_service), 32'd0);
        check("midrst_mask",    32'(e_if.mask),       32'hFF);
        check("midrst_pending", 32'(e_if.pending),    32'd0);
        e_if.irq[4] = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(5);
        check("postrst_pending", 32'(e_if.pending), 32'd0);
        check("postrst_intr",    32'(e_if.intr),    32'd0);
        check("sb_drained", 32'(exp_vec_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
